// File: rtl/i_decode_if.sv
// ID-stage bus: IF/ID latch inputs, write-back port, hazard outputs and the ID/EX latch.
interface i_decode_if;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic        MEM_WB_regwrite;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_wdata;
    logic        pc_write;
    logic        if_id_write;
    logic [1:0]  ID_EX_wb;
    logic [2:0]  ID_EX_m;
    logic [3:0]  ID_EX_ex;
    logic [31:0] ID_EX_npc;
    logic [31:0] ID_EX_readdat1;
    logic [31:0] ID_EX_readdat2;
    logic [31:0] ID_EX_sign_ext;
    logic [4:0]  ID_EX_instr_2016;
    logic [4:0]  ID_EX_instr_1511;

    modport master (
        output IF_ID_instr, IF_ID_npc, MEM_WB_regwrite, MEM_WB_rd, MEM_WB_wdata,
        input  pc_write, if_id_write, ID_EX_wb, ID_EX_m, ID_EX_ex, ID_EX_npc,
               ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext,
               ID_EX_instr_2016, ID_EX_instr_1511
    );

    modport slave (
        input  IF_ID_instr, IF_ID_npc, MEM_WB_regwrite, MEM_WB_rd, MEM_WB_wdata,
        output pc_write, if_id_write, ID_EX_wb, ID_EX_m, ID_EX_ex, ID_EX_npc,
               ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext,
               ID_EX_instr_2016, ID_EX_instr_1511
    );
endinterface

// File: rtl/i_decode.sv
// MIPS instruction-decode stage: register file, main control, sign extension,
// load-use hazard detection and the ID/EX pipeline latch.
module i_decode (
    input  logic       clk,
    input  logic       rst,
    i_decode_if.slave  bus
);
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    assign opcode = bus.IF_ID_instr[31:26];
    assign rs     = bus.IF_ID_instr[25:21];
    assign rt     = bus.IF_ID_instr[20:16];
    assign rd     = bus.IF_ID_instr[15:11];
    assign imm    = bus.IF_ID_instr[15:0];

    logic [31:0] regs_q [32];
    logic [31:0] rs_data, rt_data;
    logic        wb_hit;

    logic [1:0]  wb_q, wb_d;
    logic [2:0]  m_q, m_d;
    logic [3:0]  ex_q, ex_d;
    logic [31:0] npc_q, rd1_q, rd2_q, sext_q, sext_d;
    logic [4:0]  rt_q, rd_q;
    logic        stall;
    logic [8:0]  ctrl;

    assign wb_hit = bus.MEM_WB_regwrite && (bus.MEM_WB_rd != 5'd0);

    // Register reads with write-through so a same-cycle write-back is visible.
    always_comb begin
        rs_data = 32'd0;
        rt_data = 32'd0;
        if (rs != 5'd0) begin
            rs_data = (wb_hit && bus.MEM_WB_rd == rs) ? bus.MEM_WB_wdata : regs_q[rs];
        end
        if (rt != 5'd0) begin
            rt_data = (wb_hit && bus.MEM_WB_rd == rt) ? bus.MEM_WB_wdata : regs_q[rt];
        end
    end

    // Main control decode, packed as {wb[1:0], m[2:0], ex[3:0]}.
    always_comb begin
        ctrl = 9'd0;
        case (opcode)
            6'h00:   ctrl = 9'b10_000_1100;
            6'h23:   ctrl = 9'b11_010_0001;
            6'h2B:   ctrl = 9'b00_001_0001;
            6'h04:   ctrl = 9'b00_100_0010;
            default: ctrl = 9'd0;
        endcase
    end

    // Load-use hazard; rt == 0 still matches, which is an accepted conservative stall.
    always_comb begin
        stall = m_q[1] && ((rt_q == rs) || (rt_q == rt));
        wb_d  = stall ? 2'd0 : ctrl[8:7];
        m_d   = stall ? 3'd0 : ctrl[6:4];
        ex_d  = stall ? 4'd0 : ctrl[3:0];
        sext_d = {{16{imm[15]}}, imm};
    end

    assign bus.pc_write    = ~stall;
    assign bus.if_id_write = ~stall;

    // Register file write port; $0 is never written and reset wins over write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (wb_hit) begin
            regs_q[bus.MEM_WB_rd] <= bus.MEM_WB_wdata;
        end
    end

    // ID/EX latch loads every cycle; stalls only zero the control fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q   <= 2'd0;
            m_q    <= 3'd0;
            ex_q   <= 4'd0;
            npc_q  <= 32'd0;
            rd1_q  <= 32'd0;
            rd2_q  <= 32'd0;
            sext_q <= 32'd0;
            rt_q   <= 5'd0;
            rd_q   <= 5'd0;
        end else begin
            wb_q   <= wb_d;
            m_q    <= m_d;
            ex_q   <= ex_d;
            npc_q  <= bus.IF_ID_npc;
            rd1_q  <= rs_data;
            rd2_q  <= rt_data;
            sext_q <= sext_d;
            rt_q   <= rt;
            rd_q   <= rd;
        end
    end

    assign bus.ID_EX_wb         = wb_q;
    assign bus.ID_EX_m          = m_q;
    assign bus.ID_EX_ex         = ex_q;
    assign bus.ID_EX_npc        = npc_q;
    assign bus.ID_EX_readdat1   = rd1_q;
    assign bus.ID_EX_readdat2   = rd2_q;
    assign bus.ID_EX_sign_ext   = sext_q;
    assign bus.ID_EX_instr_2016 = rt_q;
    assign bus.ID_EX_instr_1511 = rd_q;
endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: directed literal scenarios plus randomized traffic
// compared every cycle against a behavioural model of the decode stage.
module tb_i_decode;
    logic clk = 1'b0;
    logic rst = 1'b0;
    i_decode_if bus ();

    i_decode dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: architectural registers and the expected ID/EX contents.
    logic [31:0] mregs [32];
    logic [8:0]  mctrl;
    logic [31:0] mnpc, mrd1, mrd2, msext;
    logic [4:0]  mrt, mrd;
    bit          mvalid = 1'b0;

    function automatic logic [8:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b10_000_1100;
            6'h23:   return 9'b11_010_0001;
            6'h2B:   return 9'b00_001_0001;
            6'h04:   return 9'b00_100_0010;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (bus.MEM_WB_regwrite && bus.MEM_WB_rd == r) return bus.MEM_WB_wdata;
        return mregs[r];
    endfunction

    function automatic bit mstall();
        logic [4:0] rs, rt;
        rs = bus.IF_ID_instr[25:21];
        rt = bus.IF_ID_instr[20:16];
        return mctrl[5] && (mrt == rs || mrt == rt);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each rising edge from the inputs present during the cycle.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            mctrl = 9'd0; mnpc = 0; mrd1 = 0; mrd2 = 0; msext = 0; mrt = 0; mrd = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            logic [31:0] i;
            logic        st;
            i  = bus.IF_ID_instr;
            st = mstall();
            mctrl = st ? 9'd0 : ctrl_of(i[31:26]);
            mnpc  = bus.IF_ID_npc;
            mrd1  = mread(i[25:21]);
            mrd2  = mread(i[20:16]);
            msext = {{16{i[15]}}, i[15:0]};
            mrt   = i[20:16];
            mrd   = i[15:11];
            if (bus.MEM_WB_regwrite && bus.MEM_WB_rd != 5'd0)
                mregs[bus.MEM_WB_rd] = bus.MEM_WB_wdata;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("wb",   {30'd0, bus.ID_EX_wb}, {30'd0, mctrl[8:7]});
            chk("m",    {29'd0, bus.ID_EX_m},  {29'd0, mctrl[6:4]});
            chk("ex",   {28'd0, bus.ID_EX_ex}, {28'd0, mctrl[3:0]});
            chk("npc",  bus.ID_EX_npc, mnpc);
            chk("rd1",  bus.ID_EX_readdat1, mrd1);
            chk("rd2",  bus.ID_EX_readdat2, mrd2);
            chk("sext", bus.ID_EX_sign_ext, msext);
            chk("rt",   {27'd0, bus.ID_EX_instr_2016}, {27'd0, mrt});
            chk("rd",   {27'd0, bus.ID_EX_instr_1511}, {27'd0, mrd});
            chk("pc_write",    {31'd0, bus.pc_write},    {31'd0, ~mstall()});
            chk("if_id_write", {31'd0, bus.if_id_write}, {31'd0, ~mstall()});
        end
    end

    task automatic apply(input logic r, input logic [31:0] instr, input logic we,
                         input logic [4:0] wrd, input logic [31:0] wd);
        rst = r;
        bus.IF_ID_instr     = instr;
        bus.IF_ID_npc       = $urandom;
        bus.MEM_WB_regwrite = we;
        bus.MEM_WB_rd       = wrd;
        bus.MEM_WB_wdata    = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle with a lw on the bus.
        apply(1'b1, 32'h8C220004, 1'b0, 5'd0, 32'd0);
        tick(); tick();
        chk("rst_wb",  {30'd0, bus.ID_EX_wb}, 32'd0);
        chk("rst_m",   {29'd0, bus.ID_EX_m}, 32'd0);
        chk("rst_ex",  {28'd0, bus.ID_EX_ex}, 32'd0);
        chk("rst_npc", bus.ID_EX_npc, 32'd0);
        chk("rst_pcw", {31'd0, bus.pc_write}, 32'd1);
        chk("rst_ifw", {31'd0, bus.if_id_write}, 32'd1);
        apply(1'b0, 32'h8C220004, 1'b0, 5'd0, 32'd0);
        tick();
        chk("lw_wb", {30'd0, bus.ID_EX_wb}, 32'd3);
        chk("lw_m",  {29'd0, bus.ID_EX_m}, 32'd2);
        chk("lw_ex", {28'd0, bus.ID_EX_ex}, 32'd1);

        // R-type with same-cycle write-back bypass.
        apply(1'b0, 32'h00000000, 1'b1, 5'd1, 32'd5);
        tick();
        apply(1'b0, 32'h00221820, 1'b1, 5'd2, 32'h0000000A);
        tick();
        chk("add_rd1", bus.ID_EX_readdat1, 32'd5);
        chk("add_rd2", bus.ID_EX_readdat2, 32'hA);
        chk("add_rdf", {27'd0, bus.ID_EX_instr_1511}, 32'd3);
        chk("add_ex",  {28'd0, bus.ID_EX_ex}, 32'hC);
        chk("add_wb",  {30'd0, bus.ID_EX_wb}, 32'd2);

        // sw with negative immediate.
        apply(1'b0, 32'hAC41FFFC, 1'b0, 5'd0, 32'd0);
        tick();
        chk("sw_sext", bus.ID_EX_sign_ext, 32'hFFFFFFFC);
        chk("sw_m",    {29'd0, bus.ID_EX_m}, 32'd1);
        chk("sw_wb",   {30'd0, bus.ID_EX_wb}, 32'd0);
        chk("sw_rt",   {27'd0, bus.ID_EX_instr_2016}, 32'd1);

        // Load-use stall lasts exactly one cycle.
        apply(1'b0, 32'h8C220000, 1'b0, 5'd0, 32'd0);
        tick();
        apply(1'b0, 32'h00432020, 1'b0, 5'd0, 32'd0);
        #1;
        chk("lu_pcw0", {31'd0, bus.pc_write}, 32'd0);
        chk("lu_ifw0", {31'd0, bus.if_id_write}, 32'd0);
        tick();
        chk("lu_bub", {23'd0, bus.ID_EX_wb, bus.ID_EX_m, bus.ID_EX_ex}, 32'd0);
        chk("lu_pcw1", {31'd0, bus.pc_write}, 32'd1);
        tick();
        chk("lu_wb", {30'd0, bus.ID_EX_wb}, 32'd2);
        chk("lu_rd", {27'd0, bus.ID_EX_instr_1511}, 32'd4);

        // $0 protection and illegal opcode.
        apply(1'b0, 32'h00000000, 1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        chk("r0_wt", bus.ID_EX_readdat1, 32'd0);
        apply(1'b0, 32'hFC000000, 1'b0, 5'd0, 32'd0);
        tick();
        chk("r0_rd", bus.ID_EX_readdat1, 32'd0);
        chk("bad_op", {23'd0, bus.ID_EX_wb, bus.ID_EX_m, bus.ID_EX_ex}, 32'd0);

        // Reset asserted in the stall cycle.
        apply(1'b0, 32'h8C220000, 1'b0, 5'd0, 32'd0);
        tick();
        apply(1'b1, 32'h00432020, 1'b1, 5'd1, 32'h12345678);
        #1;
        chk("rs_pcw0", {31'd0, bus.pc_write}, 32'd0);
        tick();
        chk("rs_m",    {29'd0, bus.ID_EX_m}, 32'd0);
        chk("rs_pcw1", {31'd0, bus.pc_write}, 32'd1);
        apply(1'b0, 32'h00221820, 1'b0, 5'd0, 32'd0);
        tick();
        chk("rs_reg1", bus.ID_EX_readdat1, 32'd0);
        chk("rs_reg2", bus.ID_EX_readdat2, 32'd0);

        // Randomized traffic, small register indices to provoke hazards and bypasses.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0]  op;
            logic [31:0] ins;
            case ($urandom_range(0, 4))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                default: op = 6'($urandom);
            endcase
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 11'($urandom)};
            apply(($urandom_range(0, 49) == 0), ins, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom);
            tick();
        end

        apply(1'b0, 32'h00000000, 1'b0, 5'd0, 32'd0);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
